thermo_sample_ctrl: RTL and testbench
=====================================

# thermo_sample_ctrl

Sequencing controller for a flash-converter thermometer front end. Requests samples from the code source, validates each captured code as a legal LSB-contiguous thermometer word, converts legal codes to binary and delivers them over a valid/ready interface. Illegal codes are resampled up to a bounded retry limit, then a sticky error is raised. The block sits between the raw thermometer source and the downstream binary consumer.

## Interface
- DATA_WIDTH, 8, thermometer code width (≥2)
- MAX_RETRY, 3, resamples allowed after an illegal code before failing (≥0)
- OUT_W (localparam), $clog2(DATA_WIDTH+1), binary output width
- clk  input  1  rising-edge clock
- resetn  input  1  reset; one clock, asynchronous assert, active-low
- enable  input  1  run request; sampled in IDLE and on OUT completion
- sampleReq  output  1  asks the source for a code; high throughout REQ
- codeValid  input  1  source code present; honoured only in REQ
- codeIn  input  DATA_WIDTH  raw thermometer code
- dataOut  output  OUT_W  binary count of ones of last legal code
- dataValid  output  1  dataOut valid; high throughout OUT
- dataReady  input  1  consumer accepts dataOut
- errFlag  output  1  sticky failure after retries exhausted
- errCount  output  8  illegal codes seen, saturates at 255
- errClr  input  1  clears errFlag and errCount; releases FAIL

## Operation
- Legal code: bits [k-1:0] all 1, bits [DATA_WIDTH-1:k] all 0, k in 0..DATA_WIDTH (all-zero and all-one legal). Binary value = k.
- States: IDLE, REQ, CHECK, OUT, FAIL.
- IDLE: enable=1 → REQ; retryCnt=0.
- REQ: sampleReq=1; codeValid=1 → capture codeIn into codeReg, → CHECK. enable ignored.
- CHECK (exactly one cycle), on codeReg:
  - legal → dataOut<=k, retryCnt<=0, → OUT.
  - illegal, retryCnt<MAX_RETRY → retryCnt++, errCount++ (sat), → REQ.
  - illegal, retryCnt==MAX_RETRY → errCount++ (sat), errFlag<=1, → FAIL.
- OUT: dataValid=1, dataOut stable; dataReady=1 → REQ if enable else IDLE.
- FAIL: no requests; errClr=1 → IDLE.
- errClr in any state clears errFlag and errCount; same-cycle increment/set wins (errCount=1, errFlag=1 if FAIL entry).
- Reset: state IDLE, sampleReq=0, dataValid=0, dataOut=0, errFlag=0, errCount=0, retryCnt=0, codeReg=0.

## Timing
- Outputs sampleReq and dataValid decode from registered state; dataOut, errFlag, errCount are registers.
- codeValid accepted in cycle N → CHECK in N+1 → dataValid high in N+2.
- Back-to-back: dataReady in cycle M with enable=1 → sampleReq high in M+1.
- Illegal code: sampleReq reasserts the cycle after CHECK; each retry costs ≥2 cycles.
- Minimum steady-state period: 3 cycles per delivered code (REQ, CHECK, OUT) with codeValid and dataReady held high.
- Reset asserted mid-operation: all outputs return to reset values immediately; in-flight code discarded.

## Configuration
- THERMO_BUBBLE_CORRECT_EN defined: codeReg passes through a majority-of-three filter before checking; bit i (0<i<DATA_WIDTH-1) = maj(c[i-1],c[i],c[i+1]), bits 0 and DATA_WIDTH-1 unchanged. Filter is combinational; CHECK latency unchanged.
- Undefined: codeReg checked raw; any bubble is illegal.

## Structure
- Package thermo_pkg: state enum typedef, OUT_W width function, errCount width constant (8), bubble-filter function.
- Sub-module thermo_check: combinational; input code, outputs isLegal and onesCount (OUT_W). Instantiated once on the (optionally filtered) codeReg.

## Test plan
- enable=1, codeValid/dataReady high, codeIn=8'b0000_0111 → dataValid 2 cycles after capture, dataOut=3, errCount=0.
- codeIn=8'h00 then 8'hFF → dataOut=0 then 8; both legal.
- Illegal 8'b0001_0111 held, MAX_RETRY=3 → 4 captures, errCount=4, errFlag=1, state FAIL, sampleReq low; errClr → errFlag=0, errCount=0, IDLE.
- Same code with THERMO_BUBBLE_CORRECT_EN → dataOut=4, errCount=0.
- Illegal, illegal, then 8'b0011_1111 → dataOut=6, errCount=2, errFlag=0, retryCnt reset.
- dataReady low for 5 cycles in OUT → dataValid and dataOut stable, no sampleReq; resetn pulse mid-REQ → all outputs at reset values.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared types and helpers for the thermometer sample controller.
// Holds the FSM state enum, width helpers and the optional bubble filter.
package thermo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CHECK,
        ST_OUT,
        ST_FAIL
    } state_t;

    localparam int ERR_CNT_W  = 8;
    localparam int FILT_MAX_W = 64;

    function automatic int out_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Majority-of-three over interior bits; end bits pass through untouched.
    function automatic logic [FILT_MAX_W-1:0] bubble_filter(input logic [FILT_MAX_W-1:0] c,
                                                            input int w);
        logic [FILT_MAX_W-1:0] f;
        f = c;
        for (int i = 1; i < FILT_MAX_W - 1; i++) begin
            if (i < w - 1)
                f[i] = (c[i-1] & c[i]) | (c[i] & c[i+1]) | (c[i-1] & c[i+1]);
        end
        return f;
    endfunction

endpackage

// File: rtl/thermo_check.sv
// Combinational thermometer-code checker: flags LSB-contiguous codes and
// reports the number of ones, which equals the binary value of a legal code.
module thermo_check #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_W      = 4
) (
    input  logic [DATA_WIDTH-1:0] code,
    output logic                  isLegal,
    output logic [OUT_W-1:0]      onesCount
);

    logic [OUT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] mask;

    // A legal code is exactly the contiguous mask built from its own popcount.
    always_comb begin
        cnt  = '0;
        mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            cnt = cnt + OUT_W'(code[i]);
        for (int i = 0; i < DATA_WIDTH; i++)
            mask[i] = (i < int'(cnt));
        isLegal   = (code == mask);
        onesCount = cnt;
    end

endmodule

// File: rtl/thermo_sample_ctrl.sv
// Sampling sequencer for a flash thermometer front end: request, validate,
// convert, deliver, with bounded resampling. Optional THERMO_BUBBLE_CORRECT_EN.
module thermo_sample_ctrl
    import thermo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_RETRY  = 3,
    localparam int OUT_W      = out_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    output logic                  sampleReq,
    input  logic                  codeValid,
    input  logic [DATA_WIDTH-1:0] codeIn,
    output logic [OUT_W-1:0]      dataOut,
    output logic                  dataValid,
    input  logic                  dataReady,
    output logic                  errFlag,
    output logic [ERR_CNT_W-1:0]  errCount,
    input  logic                  errClr
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] code_reg;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [DATA_WIDTH-1:0] check_code;
    logic                  is_legal;
    logic [OUT_W-1:0]      ones_count;

`ifdef THERMO_BUBBLE_CORRECT_EN
    logic [FILT_MAX_W-1:0] filt_wide;
    logic                  unused_filt_hi;
    assign filt_wide      = bubble_filter(FILT_MAX_W'(code_reg), DATA_WIDTH);
    assign check_code     = filt_wide[DATA_WIDTH-1:0];
    assign unused_filt_hi = ^filt_wide[FILT_MAX_W-1:DATA_WIDTH];
`else
    assign check_code = code_reg;
`endif

    thermo_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_W      (OUT_W)
    ) u_check (
        .code      (check_code),
        .isLegal   (is_legal),
        .onesCount (ones_count)
    );

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign sampleReq = (state == ST_REQ);
    assign dataValid = (state == ST_OUT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            code_reg  <= '0;
            retry_cnt <= '0;
            dataOut   <= '0;
            errFlag   <= 1'b0;
            errCount  <= '0;
        end else begin
            if (errClr) begin
                errFlag  <= 1'b0;
                errCount <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state     <= ST_REQ;
                        retry_cnt <= '0;
                    end
                end
                ST_REQ: begin
                    if (codeValid) begin
                        code_reg <= codeIn;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (is_legal) begin
                        dataOut   <= ones_count;
                        retry_cnt <= '0;
                        state     <= ST_OUT;
                    end else begin
                        // A same-cycle clear loses to the new error: count restarts at one.
                        errCount <= errClr ? ERR_CNT_W'(1) : sat_inc(errCount);
                        if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ST_REQ;
                        end else begin
                            errFlag <= 1'b1;
                            state   <= ST_FAIL;
                        end
                    end
                end
                ST_OUT: begin
                    if (dataReady)
                        state <= enable ? ST_REQ : ST_IDLE;
                end
                ST_FAIL: begin
                    if (errClr)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_thermo_sample_ctrl.sv
// Scoreboard bench for thermo_sample_ctrl: expected binary values are queued
// as codes are driven and popped when the DUT hands data to the consumer.
module tb_thermo_sample_ctrl;

    localparam int DW    = 8;
    localparam int MR    = 3;
    localparam int OW    = $clog2(DW + 1);

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic          sampleReq;
    logic          codeValid;
    logic [DW-1:0] codeIn;
    logic [OW-1:0] dataOut;
    logic          dataValid;
    logic          dataReady;
    logic          errFlag;
    logic [7:0]    errCount;
    logic          errClr;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];
    int exp_err;
    int exp_retry;
    int exp_flag;

    thermo_sample_ctrl #(
        .DATA_WIDTH (DW),
        .MAX_RETRY  (MR)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .sampleReq (sampleReq),
        .codeValid (codeValid),
        .codeIn    (codeIn),
        .dataOut   (dataOut),
        .dataValid (dataValid),
        .dataReady (dataReady),
        .errFlag   (errFlag),
        .errCount  (errCount),
        .errClr    (errClr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference: count trailing ones from the LSB, then require nothing above.
    function automatic int ref_decode(input logic [DW-1:0] raw, output bit legal);
        logic [DW-1:0] c;
        int k;
        c = raw;
`ifdef THERMO_BUBBLE_CORRECT_EN
        for (int i = 1; i < DW - 1; i++) begin
            int s;
            s = int'(raw[i-1]) + int'(raw[i]) + int'(raw[i+1]);
            c[i] = (s >= 2);
        end
`endif
        k = 0;
        while (k < DW && c[k]) k++;
        legal = 1'b1;
        for (int i = k; i < DW; i++)
            if (c[i]) legal = 1'b0;
        return k;
    endfunction

    task automatic model_reset();
        exp_err   = 0;
        exp_retry = 0;
        exp_flag  = 0;
    endtask

    // Drive one code into REQ, update the model, and check CHECK/OUT timing.
    task automatic send_code(input logic [DW-1:0] c);
        int  k;
        int  waited;
        bit  legal;
        waited = 0;
        @(negedge clk);
        while (!sampleReq && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!sampleReq) begin
            chk("sreq_timeout", 0, 1);
            return;
        end
        codeValid = 1'b1;
        codeIn    = c;
        k = ref_decode(c, legal);
        if (legal) begin
            exp_q.push_back(k);
            exp_retry = 0;
        end else begin
            if (exp_err < 255) exp_err++;
            if (exp_retry == MR) exp_flag = 1;
            else exp_retry++;
        end
        @(posedge clk);
        #1 codeValid = 1'b0;
        @(negedge clk);
        chk("check_dvalid", dataValid, 0);
        chk("check_sreq", sampleReq, 0);
        @(negedge clk);
        chk("out_dvalid", dataValid, int'(legal));
        chk("retry_sreq", sampleReq, int'(!legal && exp_flag == 0));
        chk("err_count", errCount, exp_err);
        chk("err_flag", errFlag, exp_flag);
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && dataValid && dataReady) begin
            if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
            else chk("data_out", dataOut, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0, expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        resetn    = 1'b0;
        enable    = 1'b0;
        codeValid = 1'b0;
        codeIn    = '0;
        dataReady = 1'b0;
        errClr    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_sreq", sampleReq, 0);
        chk("rst_dvalid", dataValid, 0);
        chk("rst_dout", dataOut, 0);
        chk("rst_eflag", errFlag, 0);
        chk("rst_ecount", errCount, 0);

        @(posedge clk);
        #1 resetn = 1'b1;
        enable    = 1'b1;
        dataReady = 1'b1;

        send_code(8'b0000_0111);
        @(negedge clk);
        chk("b2b_sreq", sampleReq, 1);
        send_code(8'h00);
        send_code(8'hFF);

`ifdef THERMO_BUBBLE_CORRECT_EN
        send_code(8'b0001_0111);
`else
        for (int i = 0; i <= MR; i++) send_code(8'b0001_0111);
        repeat (3) @(negedge clk);
        chk("fail_sreq", sampleReq, 0);
        chk("fail_flag", errFlag, 1);
        chk("fail_count", errCount, MR + 1);
        @(posedge clk);
        #1 enable = 1'b0;
        errClr = 1'b1;
        @(posedge clk);
        #1 errClr = 1'b0;
        model_reset();
        @(negedge clk);
        chk("clr_flag", errFlag, 0);
        chk("clr_count", errCount, 0);
        @(negedge clk);
        chk("idle_sreq", sampleReq, 0);
        chk("idle_dvalid", dataValid, 0);
        @(posedge clk);
        #1 enable = 1'b1;
`endif

        send_code(8'h81);
        send_code(8'h81);
        send_code(8'b0011_1111);
        for (int i = 0; i < MR; i++) send_code(8'h81);
        send_code(8'b0000_0011);

        @(posedge clk);
        #1 dataReady = 1'b0;
        send_code(8'b0001_1111);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_dvalid", dataValid, 1);
            chk("stall_dout", dataOut, 5);
            chk("stall_sreq", sampleReq, 0);
        end
        @(posedge clk);
        #1 dataReady = 1'b1;

        @(negedge clk);
        while (!sampleReq) @(negedge clk);
        @(posedge clk);
        #1 codeValid = 1'b1;
        codeIn = 8'b0000_0111;
        resetn = 1'b0;
        #1;
        chk("mrst_sreq", sampleReq, 0);
        chk("mrst_dvalid", dataValid, 0);
        chk("mrst_dout", dataOut, 0);
        chk("mrst_eflag", errFlag, 0);
        chk("mrst_ecount", errCount, 0);
        @(posedge clk);
        #1 codeValid = 1'b0;
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_discard", dataValid, 0);
        end
        send_code(8'b0000_0001);

        repeat (2) @(negedge clk);
        chk("q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
